data_split: RTL and testbench
=============================

DATA_SPLIT -- requirements
Module: data_split

Interface
REQ-001 SHALL have parameter DW, default 8, output beat width in bits.
REQ-002 SHALL have parameter NB, default 4, beats per input word (NB >= 2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
REQ-005 data_in  input  DW*NB  wide word from upstream.
REQ-006 valid_a  input  1  data_in valid.
REQ-007 ready_a  output  1  block can accept data_in this cycle.
REQ-008 valid_b  output  1  data_out valid (registered).
REQ-009 ready_b  input  1  downstream accepts data_out this cycle.
REQ-010 data_out  output  DW  current beat (registered).
REQ-011 last_b  output  1  current beat is beat NB-1 of its word.

Function
REQ-012 Upstream handshake SHALL occur when valid_a && ready_a at a rising clk edge; downstream handshake when valid_b && ready_b.
REQ-013 SHALL implement two states: IDLE (valid_b=0) and SEND (valid_b=1); valid_b SHALL equal (state==SEND).
REQ-014 IDLE -> SEND on upstream handshake: word latched into holding register, beat counter cleared to 0, valid_b high on the next cycle (latency 1 cycle, accept edge to first beat valid).
REQ-015 ready_a SHALL be combinational: 1 in IDLE; in SEND, 1 only when ready_b && beat counter==NB-1; otherwise 0.
REQ-016 While valid_b && !ready_b, data_out, last_b and beat counter SHALL hold unchanged (no beat dropped or repeated).
REQ-017 Downstream handshake with counter < NB-1: counter increments, next beat presented on the following cycle, valid_b stays 1.
REQ-018 Downstream handshake with counter == NB-1 and valid_a=1: new word SHALL be latched in the same edge, counter -> 0, valid_b stays 1 (zero-bubble back-to-back).
REQ-019 Downstream handshake with counter == NB-1 and valid_a=0: state -> IDLE, valid_b -> 0 next cycle.
REQ-020 last_b SHALL equal valid_b && (counter == NB-1); 0 whenever valid_b=0.
REQ-021 Beat counter width SHALL be ceil(log2(NB)); it SHALL never exceed NB-1 (no wrap past last beat).
REQ-022 valid_a in SEND with ready_a=0 SHALL be ignored; data_in not sampled; upstream holds it.
REQ-023 data_out in IDLE SHALL hold last presented beat value (don't-care to downstream, but stable).
REQ-024 Exactly NB downstream handshakes SHALL occur per accepted word; no partial words emitted.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, valid_b=0, last_b=0, data_out=0, counter=0, holding register=0.
REQ-026 ready_a SHALL read 1 during and after reset (IDLE); valid_a while rst_n low SHALL not be captured.
REQ-027 Reset asserted mid-word SHALL discard remaining beats; no beat of that word emitted after release.

Configuration
REQ-028 Macro DATA_SPLIT_MSB_FIRST_EN SHALL select beat order.
REQ-029 Without DATA_SPLIT_MSB_FIRST_EN: beat k = data_in[DW*k +: DW] (LSB slice first).
REQ-030 With DATA_SPLIT_MSB_FIRST_EN: beat k = data_in[DW*(NB-1-k) +: DW] (MSB slice first); all handshake timing identical.

Verification
REQ-031 Default params, LSB-first: accept 0x44332211, ready_b=1 -> data_out 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after accept; last_b only on 0x44; then valid_b=0.
REQ-032 Backpressure: ready_b=0 for 3 cycles during beat 1 of 0xDDCCBBAA -> data_out holds 0xBB, valid_b=1, ready_a=0 throughout; resumes 0xCC, 0xDD.
REQ-033 Back-to-back: valid_a held with 0x04030201 then 0x08070605, ready_b=1 -> 8 beats 0x01..0x08 with valid_b continuously 1, ready_a=1 only on cycles of beats 0x04 and idle.
REQ-034 Reset mid-word: assert rst_n=0 after beat 0x22 of 0x44332211 -> valid_b, last_b, data_out immediately 0; after release no 0x33/0x44 appear; next word starts at beat 0.
REQ-035 With DATA_SPLIT_MSB_FIRST_EN: accept 0x44332211 -> beats 0x44,0x33,0x22,0x11, last_b on 0x11.
REQ-036 Random valid_a/ready_b for 10k cycles: scoreboard reassembles words; every accepted word reproduced exactly, in order, NB beats each.

Source files
------------

// File: rtl/data_split.sv
// rtl/data_split.sv - wide-word to DW-bit beat serializer (DATA_SPLIT_MSB_FIRST_EN selects MSB-slice-first order)
module data_split #(
  parameter int DW = 8,
  parameter int NB = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DW*NB-1:0]   data_in,
  input  logic               valid_a,
  output logic               ready_a,
  output logic               valid_b,
  input  logic               ready_b,
  output logic [DW-1:0]      data_out,
  output logic               last_b
);

  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [DW*NB-1:0]  hold, hold_nxt;
  logic [DW-1:0]     dout, dout_nxt;

  // Pick beat k of a word in the configured slice order.
  function automatic logic [DW-1:0] beat(input logic [DW*NB-1:0] w, input logic [CW-1:0] k);
    int idx;
`ifdef DATA_SPLIT_MSB_FIRST_EN
    idx = NB - 1 - int'(k);
`else
    idx = int'(k);
`endif
    return w[DW*idx +: DW];
  endfunction

  // State, counter, holding word and presented beat; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      dout  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hold  <= hold_nxt;
      dout  <= dout_nxt;
    end
  end

  // Next state: accept in IDLE, step through beats in SEND, reload on the last beat if a word waits.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
    dout_nxt  = dout;
    ready_a   = 1'b0;
    case (state)
      IDLE: begin
        ready_a = 1'b1;
        if (valid_a) begin
          state_nxt = SEND;
          cnt_nxt   = '0;
          hold_nxt  = data_in;
          dout_nxt  = beat(data_in, '0);
        end
      end
      SEND: begin
        if (ready_b) begin
          if (cnt != LAST) begin
            cnt_nxt  = cnt + 1'b1;
            dout_nxt = beat(hold, cnt + 1'b1);
          end else begin
            ready_a = 1'b1;
            if (valid_a) begin
              cnt_nxt  = '0;
              hold_nxt = data_in;
              dout_nxt = beat(data_in, '0);
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign valid_b  = (state == SEND);
  assign last_b   = valid_b && (cnt == LAST);
  assign data_out = dout;

endmodule

// File: tb/tb_data_split.sv
// tb/tb_data_split.sv - randomized and directed bench for data_split with a queue-based beat model
module tb_data_split;

  localparam int DW = 8;
  localparam int NB = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DW*NB-1:0]  data_in;
  logic              valid_a;
  logic              ready_a;
  logic              valid_b;
  logic              ready_b;
  logic [DW-1:0]     data_out;
  logic              last_b;

  int checks = 0;
  int errors = 0;

  data_split #(.DW(DW), .NB(NB)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_a(valid_a), .ready_a(ready_a),
    .valid_b(valid_b), .ready_b(ready_b), .data_out(data_out), .last_b(last_b)
  );

  always #5 clk = ~clk;

  // Reference: queue of beats still owed downstream for the word in flight.
  logic [DW-1:0]     exp_q[$];
  logic [DW*NB-1:0]  words_q[$];
  logic [DW-1:0]     last_out = '0;
  logic              acc_flag = 1'b0;
  logic [DW*NB-1:0]  asm_word = '0;
  int                asm_cnt = 0;

  function automatic logic [DW-1:0] beat_of(input logic [DW*NB-1:0] w, input int k);
`ifdef DATA_SPLIT_MSB_FIRST_EN
    return w[DW*(NB-1-k) +: DW];
`else
    return w[DW*k +: DW];
`endif
  endfunction

  function automatic logic exp_ready_a();
    return (exp_q.size() == 0) || (ready_b && exp_q.size() == 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on each edge; also reassemble the DUT's handshaken beats into words.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      words_q.delete();
      last_out = '0;
      acc_flag = 1'b0;
      asm_cnt  = 0;
      asm_word = '0;
    end else begin
      logic acc;
      acc = valid_a && exp_ready_a();
      if (valid_b && ready_b) begin
        int pos;
`ifdef DATA_SPLIT_MSB_FIRST_EN
        pos = NB - 1 - asm_cnt;
`else
        pos = asm_cnt;
`endif
        asm_word[DW*pos +: DW] = data_out;
        asm_cnt++;
        if (asm_cnt == NB) begin
          asm_cnt = 0;
          if (words_q.size() == 0) chk("reassembly_underflow", 32'd0, 32'd1);
          else chk("reassembled_word", 32'(asm_word), 32'(words_q.pop_front()));
        end
      end
      if (exp_q.size() > 0 && ready_b) void'(exp_q.pop_front());
      if (acc) begin
        for (int k = 0; k < NB; k++) exp_q.push_back(beat_of(data_in, k));
        words_q.push_back(data_in);
      end
      if (exp_q.size() > 0) last_out = exp_q[0];
      acc_flag = acc;
    end
  end

  // Compare DUT outputs with the model every cycle, just after the inputs settle.
  always begin
    @(negedge clk);
    #1;
    chk("valid_b", 32'(valid_b), 32'(exp_q.size() > 0));
    chk("last_b", 32'(last_b), 32'(exp_q.size() == 1));
    chk("data_out", 32'(data_out), 32'(exp_q.size() > 0 ? exp_q[0] : last_out));
    chk("ready_a", 32'(ready_a), 32'(exp_ready_a()));
  end

  logic [7:0] seq_a[4];
  logic [7:0] seq_b[4];
  logic [7:0] seq_c[8];

  initial begin
`ifdef DATA_SPLIT_MSB_FIRST_EN
    seq_a = '{8'h44, 8'h33, 8'h22, 8'h11};
    seq_b = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    seq_c = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
`else
    seq_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    seq_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    seq_c = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`endif
    rst_n = 1'b0; valid_a = 1'b1; ready_b = 1'b0; data_in = 32'hDEADBEEF;
    #1;
    chk("rst_valid_b", 32'(valid_b), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_ready_a", 32'(ready_a), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); valid_a = 1'b0; #2 rst_n = 1'b1;
    chk("post_rst_valid_b", 32'(valid_b), 32'd0);

    // Single word, free-flowing downstream.
    @(negedge clk); valid_a = 1'b1; data_in = 32'h44332211; ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); valid_a = 1'b0; #1;
      chk("w1_beat", 32'(data_out), 32'(seq_a[i]));
      chk("w1_last", 32'(last_b), 32'(i == 3));
      chk("w1_valid", 32'(valid_b), 32'd1);
    end
    @(negedge clk); #1;
    chk("w1_idle_valid", 32'(valid_b), 32'd0);

    // Backpressure during beat 1.
    @(negedge clk); valid_a = 1'b1; data_in = 32'hDDCCBBAA; ready_b = 1'b1;
    @(negedge clk); valid_a = 1'b0; #1 chk("bp_beat0", 32'(data_out), 32'(seq_b[0]));
    @(negedge clk); ready_b = 1'b0; valid_a = 1'b1; data_in = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_data", 32'(data_out), 32'(seq_b[1]));
      chk("bp_hold_valid", 32'(valid_b), 32'd1);
      chk("bp_hold_ready_a", 32'(ready_a), 32'd0);
      @(negedge clk);
    end
    valid_a = 1'b0; ready_b = 1'b1;
    #1 chk("bp_release", 32'(data_out), 32'(seq_b[1]));
    @(negedge clk); #1 chk("bp_beat2", 32'(data_out), 32'(seq_b[2]));
    @(negedge clk); #1 chk("bp_beat3", 32'(data_out), 32'(seq_b[3]));
    @(negedge clk); #1 chk("bp_idle", 32'(valid_b), 32'd0);

    // Back-to-back words with valid_a held.
    @(negedge clk); valid_a = 1'b1; data_in = 32'h04030201; ready_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) data_in = 32'h08070605;
      if (i == 4) valid_a = 1'b0;
      #1;
      chk("b2b_beat", 32'(data_out), 32'(seq_c[i]));
      chk("b2b_valid", 32'(valid_b), 32'd1);
      chk("b2b_ready_a", 32'(ready_a), 32'((i % 4) == 3));
    end
    @(negedge clk); #1 chk("b2b_idle", 32'(valid_b), 32'd0);

    // Reset in the middle of a word.
    @(negedge clk); valid_a = 1'b1; data_in = 32'h44332211; ready_b = 1'b1;
    @(negedge clk); valid_a = 1'b0;
    @(negedge clk); #1 chk("mid_beat1", 32'(data_out), 32'(seq_a[1]));
    #1 rst_n = 1'b0; #1;
    chk("mid_rst_valid", 32'(valid_b), 32'd0);
    chk("mid_rst_last", 32'(last_b), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_ready_a", 32'(ready_a), 32'd1);
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1 chk("mid_no_leftover", 32'(valid_b), 32'd0);
    end
    @(negedge clk); valid_a = 1'b1; data_in = 32'h44332211;
    @(negedge clk); valid_a = 1'b0; #1 chk("mid_restart_beat0", 32'(data_out), 32'(seq_a[0]));
    repeat (4) @(negedge clk);

    // Random traffic; upstream holds a word until it is taken.
    valid_a = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (!valid_a || acc_flag) begin
        valid_a = ($urandom_range(0, 3) != 0);
        data_in = $urandom;
      end
      ready_b = ($urandom_range(0, 3) != 0);
    end
    valid_a = 1'b0; ready_b = 1'b1;
    repeat (NB + 2) @(negedge clk);
    #1 chk("drain_words", 32'(words_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
